// File: rtl/rot_pkg.sv
// Shared constants and types for the round-robin rotate arbiter.
package rot_pkg;

  localparam int ROT_WIDTH = 4;
  localparam int ROT_SELW  = 2;
  localparam int CNT_W     = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rot_right.sv
// Combinational right-rotate: shifted_q[i] = q[(i + sel) mod WIDTH].
module rot_right #(
  parameter int WIDTH = 4,
  parameter int SELW  = 2
) (
  input  logic [WIDTH-1:0] q,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] shifted_q
);

  // SELW-bit index arithmetic wraps modulo WIDTH for free.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam logic [SELW-1:0] IDX = SELW'(i);
    logic [SELW-1:0] src;
    assign src          = IDX + sel;
    assign shifted_q[i] = q[src];
  end

endmodule

// File: rtl/rot_arbiter.sv
// Two requesters share one right-rotator; round-robin grant, registered
// result on a single valid/ready port tagged with the winner's id.
module rot_arbiter
  import rot_pkg::*;
#(
  parameter int WIDTH = ROT_WIDTH,
  parameter int SELW  = ROT_SELW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_q,
  input  logic [SELW-1:0]  req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_q,
  input  logic [SELW-1:0]  req1_sel,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  out_state_e                  state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic [WIDTH-1:0]            data_q, data_d;
  logic                        id_q, id_d;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;

  logic                        win_any, win_id;
  logic                        can_accept, xfer;
  logic [WIDTH-1:0]            win_q, rot_q;
  logic [SELW-1:0]             win_sel;

  // Round robin: under contention the requester that did not win last time goes.
  always_comb begin
    win_any = req0_valid | req1_valid;
    win_id  = 1'b0;
    if (req0_valid && req1_valid) win_id = ~last_grant_q;
    else if (req1_valid)          win_id = 1'b1;
  end

  assign can_accept = (state_q == EMPTY) || out_ready;
  // rst_n gating keeps readies low while reset is being sampled.
  assign xfer       = rst_n && can_accept && win_any;
  assign req0_ready = xfer && !win_id;
  assign req1_ready = xfer &&  win_id;

  assign win_q   = win_id ? req1_q   : req0_q;
  assign win_sel = win_id ? req1_sel : req0_sel;

  rot_right #(.WIDTH(WIDTH), .SELW(SELW)) u_rot (
    .q         (win_q),
    .sel       (win_sel),
    .shifted_q (rot_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (xfer) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    data_d       = data_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    if (xfer) begin
      last_grant_d  = win_id;
      data_d        = rot_q;
      id_d          = win_id;
      cnt_d[win_id] = sat_inc(cnt_q[win_id]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign out_id     = id_q;
  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];

endmodule

// File: tb/tb_rot_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and compares on every output transfer.
module tb_rot_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_q, req1_q;
  logic [1:0] req0_sel, req1_sel;
  logic       out_valid, out_id, out_ready;
  logic [3:0] out_data;
  logic [7:0] grant_cnt0, grant_cnt1;

  typedef struct packed {
    logic       id;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  rot_arbiter #(.WIDTH(4), .SELW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_q     (req0_q),
    .req0_sel   (req0_sel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_q     (req1_q),
    .req1_sel   (req1_sel),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference rotate: slide a doubled word right by sel.
  function automatic logic [3:0] rotr(input logic [3:0] q, input logic [1:0] sel);
    logic [7:0] dbl;
    dbl = {q, q} >> sel;
    return dbl[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every output transfer must match the oldest expected item.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got id=%0d data=%b with empty scoreboard", out_id, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_id",   32'(out_id),   32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] t1_exp [4];
    logic [3:0] q5;
    logic [1:0] s5;
    logic       eid;
    t1_exp = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};

    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_q = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_q = '0; req1_sel = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_id",    32'(out_id),    0);
    chk("rst_cnt0",      32'(grant_cnt0), 0);
    chk("rst_cnt1",      32'(grant_cnt1), 0);
    rst_n = 1'b1;

    // Requester 0 alone, sel sweeps 0..3.
    out_ready = 1'b1; req0_valid = 1'b1; req0_q = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      req0_sel = 2'(k);
      #6;
      chk("t1_rdy0", 32'(req0_ready), 1);
      sb.push_back('{id: 1'b0, data: t1_exp[k]});
      tick();
    end
    req0_valid = 1'b0;
    tick(); tick();
    chk("t1_cnt0", 32'(grant_cnt0), 4);
    chk("t1_cnt1", 32'(grant_cnt1), 0);

    // Contention from reset: 0,1,0,1,...
    reset_dut();
    req0_valid = 1'b1; req0_q = 4'b0001; req0_sel = 2'd1;
    req1_valid = 1'b1; req1_q = 4'b1000; req1_sel = 2'd3;
    for (int k = 0; k < 6; k++) begin
      eid = (k % 2 == 1);
      #6;
      chk("t2_rdy0", 32'(req0_ready), 32'(!eid));
      chk("t2_rdy1", 32'(req1_ready), 32'(eid));
      sb.push_back('{id: eid, data: eid ? 4'b0001 : 4'b1000});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    // Backpressure: fill, stall 5 cycles, then drain + accept together.
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_q = 4'b0110; req0_sel = 2'd1;
    #6;
    chk("t3_fill_rdy0", 32'(req0_ready), 1);
    sb.push_back('{id: 1'b0, data: 4'b0011});
    tick();
    req0_q = 4'b1001; req0_sel = 2'd2;
    req1_valid = 1'b1; req1_q = 4'b1000; req1_sel = 2'd3;
    for (int k = 0; k < 5; k++) begin
      #6;
      chk("t3_stall_rdy0", 32'(req0_ready), 0);
      chk("t3_stall_rdy1", 32'(req1_ready), 0);
      chk("t3_stall_vld",  32'(out_valid), 1);
      chk("t3_stall_data", 32'(out_data), 32'(4'b0011));
      chk("t3_stall_id",   32'(out_id), 0);
      tick();
    end
    out_ready = 1'b1;
    #6;
    chk("t3_b2b_rdy1", 32'(req1_ready), 1);
    chk("t3_b2b_rdy0", 32'(req0_ready), 0);
    sb.push_back('{id: 1'b1, data: 4'b0001});
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    // Reset while FULL with both requesters valid; held result is dropped.
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_q = 4'b0001; req0_sel = 2'd1;
    req1_valid = 1'b1; req1_q = 4'b1000; req1_sel = 2'd3;
    tick();
    chk("t4_full", 32'(out_valid), 1);
    rst_n = 1'b0; out_ready = 1'b1;
    #6;
    chk("t4_rst_rdy0", 32'(req0_ready), 0);
    chk("t4_rst_rdy1", 32'(req1_ready), 0);
    tick();
    chk("t4_post_vld",  32'(out_valid), 0);
    chk("t4_post_cnt0", 32'(grant_cnt0), 0);
    chk("t4_post_cnt1", 32'(grant_cnt1), 0);
    rst_n = 1'b1;
    #6;
    chk("t4_first_rdy0", 32'(req0_ready), 1);
    chk("t4_first_rdy1", 32'(req1_ready), 0);
    sb.push_back('{id: 1'b0, data: 4'b1000});
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    // 300 transfers from requester 1: counter saturates, data stays right.
    reset_dut();
    out_ready = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      q5 = 4'(i * 7 + 3);
      s5 = 2'(i >> 4);
      req1_q = q5; req1_sel = s5;
      #6;
      chk("t5_rdy1", 32'(req1_ready), 1);
      sb.push_back('{id: 1'b1, data: rotr(q5, s5)});
      tick();
      if (i == 253) chk("t5_cnt1_254", 32'(grant_cnt1), 254);
      if (i == 254) chk("t5_cnt1_255", 32'(grant_cnt1), 255);
    end
    req1_valid = 1'b0;
    tick(); tick();
    chk("t5_cnt1_sat", 32'(grant_cnt1), 255);
    chk("t5_cnt0",     32'(grant_cnt0), 0);
    chk("sb_empty",    32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rot_arbiter.md
# rot_arbiter

Shares one right-rotate datapath between two requesters. Each requester presents a word and a rotate amount under a valid/ready handshake. Round-robin arbitration picks one requester per cycle. The rotated result is registered and presented on a single valid/ready output port, tagged with the winning requester's id. The block sits between the two producers and the shared consumer, and owns the only rotator instance in that path.

## Interface
- WIDTH, 4, data word width; must be a power of two, ≥2
- SELW, 2, rotate-amount width, equal to log2(WIDTH)

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_q  in  WIDTH  requester 0 data
- req0_sel  in  SELW  requester 0 rotate-right amount
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid, req1_q, req1_sel, req1_ready: same as requester 0, for requester 1
- out_valid  out  1  out_data holds a result
- out_data  out  WIDTH  rotated word
- out_id  out  1  requester that produced out_data
- out_ready  in  1  consumer accepts out_data
- grant_cnt0, grant_cnt1  out  8  per-requester accepted-transfer counters; saturate at 255

## Operation
- Rotation is right-rotate by sel: result bit i = q[(i+sel) mod WIDTH]. sel=0 passes q through.
- A transfer occurs on requester n when reqn_valid && reqn_ready. An output transfer occurs when out_valid && out_ready.
- Output-stage FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) || out_ready.
- Arbitration uses the last_grant register:
  - Only one requester is valid: it wins.
  - Both are valid: the requester ≠ last_grant wins.
  - Neither is valid: no grant.
- reqn_ready = can_accept && (winner==n). ready is combinational. It depends on both valids and on out_ready, and never depends on its own valid beyond the arbitration rule.
- On any requester transfer:
  - out_data ← rotate(reqn_q, reqn_sel)
  - out_id ← n
  - last_grant ← n
  - grant_cntn += 1, unless already 255
  - Next state is FULL.
- FSM transitions:
  - EMPTY → FULL when a requester transfers.
  - FULL → EMPTY when the output transfers and no requester transfers.
  - FULL → FULL when the output transfers and a requester transfers in the same cycle (back-to-back).
  - FULL → FULL when out_ready=0. out_data and out_id are held stable and both reqn_ready are 0.
- Requesters must hold q, sel and valid stable until ready. Data changes while valid && !ready are not required to be tolerated.

## Timing
- Latency: 1 cycle, from requester transfer edge to out_valid=1 with the result.
- Throughput: 1 transfer per cycle while out_ready=1. Both requesters continuously valid alternate 0,1,0,1…
- Reset (rst_n=0 sampled at a clk edge), values after that edge:
  - out_valid=0, out_data=0, out_id=0
  - state=EMPTY
  - last_grant=1, so requester 0 wins first under contention
  - grant_cnt0=grant_cnt1=0
- During reset, req0_ready=req1_ready=0.
- Reset mid-operation discards the held result with no output transfer. Any requester word presented during the reset cycle is not accepted.
- Simultaneous output drain and new accept in one cycle is legal and loses no data.
- Counter at 255 stays at 255. Transfers still complete normally.

## Structure
- Shared package rot_pkg holds:
  - default WIDTH and SELW constants
  - state enum {EMPTY, FULL}
  - the 8-bit counter width constant
- One sub-module, rot_right: purely combinational, parameterised by WIDTH and SELW, inputs q and sel, output shifted_q. rot_arbiter instantiates it once, on the winner's muxed q/sel.
- Arbiter, FSM and counters stay in rot_arbiter.

## Test plan
- Reset, then requester 0 only, q=4'b1011 and sel=0,1,2,3 on successive cycles with out_ready=1. Required: out_data = 1011, 1101, 1110, 0111, each 1 cycle after accept; out_id=0; grant_cnt0=4.
- Both requesters valid continuously (req0 q=4'b0001 sel=1, req1 q=4'b1000 sel=3), out_ready=1. Required: grants 0,1,0,1; out_data 1000 (id 0) then 0001 (id 1), repeating.
- Backpressure: fill the output, then out_ready=0 for 5 cycles. Required: out_data and out_id stable; req0_ready=req1_ready=0. On out_ready=1, a drain and a new accept occur in the same cycle.
- Reset asserted while FULL with both requesters valid. Required: next cycle out_valid=0, counters 0, no readies during reset. The first post-reset grant goes to requester 0.
- 300 accepted transfers from requester 1. Required: grant_cnt1 saturates at 255; grant_cnt0 stays 0; data remains correct.
